// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side stream adapter:
// skid-buffer occupancy encoding, default word width and a parity helper.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;

  localparam logic [1:0] OCC_ZERO = 2'd0;
  localparam logic [1:0] OCC_ONE  = 2'd1;
  localparam logic [1:0] OCC_TWO  = 2'd2;

  // Words wider than 64 bits would be truncated, so keep DATA_WIDTH <= 64.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// Drains a first-word-fall-through FIFO read port into a registered valid/ready
// stream through a two-entry skid buffer. Define FIFO_RD_STREAM_PARITY_EN to add M_PARITY.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_R_INC,
  output logic                  M_VALID,
  output logic [DATA_WIDTH-1:0] M_DATA,
  input  logic                  M_READY,
`ifdef FIFO_RD_STREAM_PARITY_EN
  output logic                  M_PARITY,
`endif
  output logic [1:0]            BUF_LEVEL
);

  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  valid_q;
  logic                  pop_s;
  logic                  take_s;
`ifdef FIFO_RD_STREAM_PARITY_EN
  logic                  head_par_q, head_par_d;
  logic                  skid_par_q, skid_par_d;
  logic                  in_par_s;

  assign in_par_s = even_parity(64'(FIFO_RD_DATA));
`endif

  // The pop decision never looks at M_READY, so there is no ready-to-R_INC path.
  assign pop_s  = ~RST & ~FIFO_EMPTY & (count_q != OCC_TWO);
  assign take_s = valid_q & M_READY;

  // Next-state for occupancy, head and skid registers.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
`ifdef FIFO_RD_STREAM_PARITY_EN
    head_par_d = head_par_q;
    skid_par_d = skid_par_q;
`endif
    case (count_q)
      OCC_ZERO: begin
        if (pop_s) begin
          head_d  = FIFO_RD_DATA;
          count_d = OCC_ONE;
`ifdef FIFO_RD_STREAM_PARITY_EN
          head_par_d = in_par_s;
`endif
        end else begin
          count_d = OCC_ZERO;
        end
      end
      OCC_ONE: begin
        if (pop_s && take_s) begin
          head_d = FIFO_RD_DATA;
`ifdef FIFO_RD_STREAM_PARITY_EN
          head_par_d = in_par_s;
`endif
        end else if (pop_s) begin
          skid_d  = FIFO_RD_DATA;
          count_d = OCC_TWO;
`ifdef FIFO_RD_STREAM_PARITY_EN
          skid_par_d = in_par_s;
`endif
        end else if (take_s) begin
          count_d = OCC_ZERO;
        end else begin
          count_d = OCC_ONE;
        end
      end
      OCC_TWO: begin
        if (take_s) begin
          head_d  = skid_q;
          count_d = OCC_ONE;
`ifdef FIFO_RD_STREAM_PARITY_EN
          head_par_d = skid_par_q;
`endif
        end else begin
          count_d = OCC_TWO;
        end
      end
      default: count_d = OCC_ZERO;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= OCC_ZERO;
      head_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
`ifdef FIFO_RD_STREAM_PARITY_EN
      head_par_q <= 1'b0;
      skid_par_q <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      valid_q <= (count_d != OCC_ZERO);
`ifdef FIFO_RD_STREAM_PARITY_EN
      head_par_q <= head_par_d;
      skid_par_q <= skid_par_d;
`endif
    end
  end

  assign FIFO_R_INC = pop_s;
  assign M_VALID    = valid_q;
  assign M_DATA     = head_q;
  assign BUF_LEVEL  = count_q;
`ifdef FIFO_RD_STREAM_PARITY_EN
  assign M_PARITY   = head_par_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a FIFO source model, an in-order
// buffer model and a delivery scoreboard, driven by directed and random steps.
module tb_fifo_rd_stream;

  logic       CLK = 1'b0;
  logic       RST;
  logic       FIFO_EMPTY;
  logic [7:0] FIFO_RD_DATA;
  logic       FIFO_R_INC;
  logic       M_VALID;
  logic [7:0] M_DATA;
  logic       M_READY;
  logic [1:0] BUF_LEVEL;
`ifdef FIFO_RD_STREAM_PARITY_EN
  logic       M_PARITY;
`endif

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FIFO_EMPTY  (FIFO_EMPTY),
    .FIFO_RD_DATA(FIFO_RD_DATA),
    .FIFO_R_INC  (FIFO_R_INC),
    .M_VALID     (M_VALID),
    .M_DATA      (M_DATA),
    .M_READY     (M_READY),
`ifdef FIFO_RD_STREAM_PARITY_EN
    .M_PARITY    (M_PARITY),
`endif
    .BUF_LEVEL   (BUF_LEVEL)
  );

  always #5 CLK = ~CLK;

  int         n_asserts = 0;
  int         n_fails   = 0;
  logic [7:0] src_q[$];   // words waiting in the FIFO
  logic [7:0] mq[$];      // words popped into the adapter, not yet delivered
  logic [7:0] sent_q[$];  // every word in the order it must arrive downstream
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    src_q.push_back(w);
    sent_q.push_back(w);
  endtask

  // One clock: drive inputs after the falling edge, check, advance the model.
  task automatic cycle(input logic rst, input logic rdy);
    logic exp_pop;
    logic exp_take;
    RST          = rst;
    M_READY      = rdy;
    FIFO_EMPTY   = (src_q.size() == 0);
    FIFO_RD_DATA = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
    #1;
    exp_pop  = !rst && (src_q.size() != 0) && (mq.size() < 2);
    exp_take = rdy && (mq.size() != 0);
    check("r_inc", 32'(FIFO_R_INC), 32'(exp_pop));
    check("m_valid", 32'(M_VALID), 32'(mq.size() != 0));
    check("buf_level", 32'(BUF_LEVEL), 32'(mq.size()));
    if (mq.size() != 0) begin
      check("m_data", 32'(M_DATA), 32'(mq[0]));
`ifdef FIFO_RD_STREAM_PARITY_EN
      check("m_parity", 32'(M_PARITY), 32'(^mq[0]));
`endif
    end
    if (stall_prev) begin
      check("stall_data", 32'(M_DATA), 32'(prev_data));
      check("stall_valid", 32'(M_VALID), 32'd1);
    end
    stall_prev = !rst && !rdy && (mq.size() != 0);
    prev_data  = M_DATA;
    if (rst) begin
      repeat (mq.size()) void'(sent_q.pop_front());
      mq.delete();
    end else begin
      if (exp_take) begin
        check("order", 32'(M_DATA), 32'(sent_q.pop_front()));
        void'(mq.pop_front());
      end
      if (exp_pop) mq.push_back(src_q.pop_front());
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int loaded;
    int guard;
    RST          = 1'b1;
    M_READY      = 1'b0;
    FIFO_EMPTY   = 1'b1;
    FIFO_RD_DATA = 8'h00;

    // Reset held with a non-empty FIFO: no pops, stream idle.
    push_word(8'hA5);
    @(negedge CLK);
    repeat (3) cycle(1'b1, 1'b0);

    // First pop right after reset; 0xA5 valid next cycle and taken.
    repeat (4) cycle(1'b0, 1'b1);
    check("single_level", 32'(BUF_LEVEL), 32'd0);

    // Full-throughput burst with ready held high.
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    repeat (11) cycle(1'b0, 1'b1);

    // Stalled burst fills the skid buffer and then stops popping.
    for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i));
    repeat (5) cycle(1'b0, 1'b0);
    check("stall_level2", 32'(BUF_LEVEL), 32'd2);
    check("stall_head", 32'(M_DATA), 32'h10);
    check("stall_no_pop", 32'(FIFO_R_INC), 32'd0);
    repeat (8) cycle(1'b0, 1'b1);

    // Parity carriers (odd and even weight) through head and skid.
    push_word(8'h07);
    push_word(8'h03);
    repeat (3) cycle(1'b0, 1'b0);
`ifdef FIFO_RD_STREAM_PARITY_EN
    check("parity_07", 32'(M_PARITY), 32'd1);
`endif
    cycle(1'b0, 1'b1);
`ifdef FIFO_RD_STREAM_PARITY_EN
    check("parity_03", 32'(M_PARITY), 32'd0);
`endif
    repeat (3) cycle(1'b0, 1'b1);

    // Random source arrivals and random ready against the scoreboard.
    loaded = 0;
    guard  = 0;
    while ((loaded < 1000 || sent_q.size() != 0) && guard < 20000) begin
      int n;
      n = $urandom_range(2, 0);
      for (int k = 0; k < n && loaded < 1000; k++) begin
        push_word(8'($urandom));
        loaded++;
      end
      cycle(1'b0, 1'($urandom_range(1, 0)));
      guard++;
    end
    check("random_drain_in_time", 32'(guard < 20000), 32'd1);
    check("random_all_delivered", 32'(sent_q.size()), 32'd0);

    // Reset while the skid buffer is full discards the buffered words.
    for (int i = 0; i < 3; i++) push_word(8'(8'h40 + i));
    repeat (3) cycle(1'b0, 1'b0);
    check("pre_reset_level", 32'(BUF_LEVEL), 32'd2);
    src_q.delete();
    cycle(1'b1, 1'b0);
    sent_q.delete();
    check("post_reset_valid", 32'(M_VALID), 32'd0);
    check("post_reset_level", 32'(BUF_LEVEL), 32'd0);
    repeat (2) cycle(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
